mmio_uart_tx: RTL

- Memory-mapped UART transmitter on the MCU data bus, downstream of the RV32I single-cycle core.
- Decodes core store/load accesses in its address window and buffers bytes in a small TX FIFO.
- Serialises each byte as 8N1 on the tx pin using a programmable baud divider.
- Gives RV32I firmware a console output that tb_rv32i-style benches can observe on a pin.

---
 rtl/mmio_uart_tx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter (TX FIFO + programmable baud divider, 8N1).
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits and set STATUS[8].

module mmio_uart_tx #(
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DIV_DEFAULT = 16'd868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bus_sel,
   input  logic        bus_we,
   input  logic [3:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        tx,
   output logic        irq_empty,
   output logic [2:0]  dbg_state
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

`ifdef UART_TX_PARITY_EN
   localparam logic PAR_FLAG = 1'b1;
`else
   localparam logic PAR_FLAG = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [15:0]     div_q, div_d;
   logic [15:0]     div_act_q, div_act_d;
   logic [7:0]      shift_q, shift_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic            par_q, par_d;
   logic            tx_q, tx_d;
   logic            ovf_q, ovf_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      mem_q [FIFO_DEPTH];

   logic            wr_en, push_req, push, pop, bit_tick;
   logic            full, empty, busy;
   logic [3:0]      count_nib;
   logic [31:0]     status;
   logic            unused_wdata;

   // Bus handshake: a bus_sel&bus_we strobe is always accepted in the cycle it
   // is presented (no ready); a TXDATA push into a full FIFO is dropped and
   // recorded in the sticky overflow flag instead of stalling the core.
   assign wr_en    = bus_sel & bus_we;
   assign push_req = wr_en && (bus_addr == 4'h0);
   assign push     = push_req && (count_q < CW'(FIFO_DEPTH));
   assign pop      = (state_q == IDLE) && (count_q != '0);
   assign bit_tick = (state_q != IDLE) && (cnt_q == div_act_q - 16'd1);

   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign busy      = (state_q != IDLE);
   assign count_nib = 4'(count_q);
   assign status    = {23'd0, PAR_FLAG, count_nib, ovf_q, busy, empty, full};

   assign unused_wdata = ^bus_wdata[31:16];

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);

      ovf_d = ovf_q;
      if (push_req && !push)                             ovf_d = 1'b1;
      else if (wr_en && bus_addr == 4'h4 && bus_wdata[3]) ovf_d = 1'b0;

      div_d = div_q;
      if (wr_en && bus_addr == 4'h8)
         div_d = (bus_wdata[15:0] == 16'd0) ? 16'd1 : bus_wdata[15:0];

      // A divisor change only takes effect at a bit boundary or while idle.
      div_act_d = (state_q == IDLE || bit_tick) ? div_q : div_act_q;
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      par_d     = par_q;
      cnt_d     = bit_tick ? 16'd0 : cnt_q + 16'd1;
      case (state_q)
         IDLE: begin
            cnt_d = 16'd0;
            if (pop) begin
               shift_d   = mem_q[rd_ptr_q];
               par_d     = ^mem_q[rd_ptr_q];
               bit_idx_d = 3'd0;
               state_d   = START;
            end
         end
         START: if (bit_tick) state_d = DATA;
         DATA: begin
            if (bit_tick) begin
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
         PARITY: if (bit_tick) state_d = STOP;
         STOP:   if (bit_tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // tx is registered from the next state so the pin never glitches.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = par_d;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= 16'd0;
         div_q     <= DIV_DEFAULT;
         div_act_q <= DIV_DEFAULT;
         shift_q   <= 8'd0;
         bit_idx_q <= 3'd0;
         par_q     <= 1'b0;
         tx_q      <= 1'b1;
         ovf_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         div_act_q <= div_act_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         par_q     <= par_d;
         tx_q      <= tx_d;
         ovf_q     <= ovf_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus_wdata[7:0];
   end

   always_comb begin
      bus_rdata = 32'd0;
      if (bus_sel) begin
         case (bus_addr)
            4'h4:    bus_rdata = status;
            4'h8:    bus_rdata = {16'd0, div_q};
            default: bus_rdata = 32'd0;
         endcase
      end
   end

   assign tx        = tx_q;
   assign irq_empty = empty && (state_q == IDLE);
   assign dbg_state = state_q;

endmodule
